// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: display read port, posted write port, RAM port and status.
// FB_ARB_STATS_EN adds the stall counter and FIFO high-water mark signals.
interface fb_arbiter_if #(
    parameter int ADDRW  = 19,
    parameter int PIXW   = 8,
    parameter int WDEPTH = 8
);
    localparam int LVLW = $clog2(WDEPTH) + 1;

    logic             disp_req;
    logic [ADDRW-1:0] disp_addr;
    logic [PIXW-1:0]  disp_data;
    logic             disp_valid;
    logic             wr_valid;
    logic             wr_ready;
    logic [ADDRW-1:0] wr_addr;
    logic [PIXW-1:0]  wr_data;
    logic             mem_en;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [PIXW-1:0]  mem_wdata;
    logic [PIXW-1:0]  mem_rdata;
    logic [LVLW-1:0]  wr_level;
    logic [1:0]       gnt;
`ifdef FB_ARB_STATS_EN
    logic [15:0]      stall_cnt;
    logic [LVLW-1:0]  max_level;
`endif

    modport slave (
`ifdef FB_ARB_STATS_EN
        output stall_cnt, max_level,
`endif
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr,
               mem_wdata, wr_level, gnt
    );

    modport master (
`ifdef FB_ARB_STATS_EN
        input  stall_cnt, max_level,
`endif
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr,
               mem_wdata, wr_level, gnt
    );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, writes are posted in a FIFO.
// Optional statistics (stall_cnt, max_level) are enabled by defining FB_ARB_STATS_EN.
module fb_arbiter #(
    parameter int ADDRW  = 19,
    parameter int PIXW   = 8,
    parameter int WDEPTH = 8
) (
    input logic         clk,
    input logic         sim_rst,
    fb_arbiter_if.slave bus
);
    localparam int LVLW = $clog2(WDEPTH) + 1;
    localparam int PTRW = $clog2(WDEPTH);

    logic [ADDRW-1:0] q_addr [WDEPTH];
    logic [PIXW-1:0]  q_data [WDEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [LVLW-1:0]  level;
    logic             push;
    logic             pop;
    logic             rd_pend;

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign bus.wr_ready = (level < LVLW'(WDEPTH));
    assign bus.wr_level = level;
    assign push         = bus.wr_valid && bus.wr_ready;
    assign pop          = !bus.disp_req && (level != '0);

    always_comb begin
        bus.gnt       = 2'b00;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = q_addr[rd_ptr];
        bus.mem_wdata = q_data[rd_ptr];
        if (bus.disp_req) begin
            bus.gnt      = 2'b01;
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.disp_addr;
        end else if (level != '0) begin
            bus.gnt    = 2'b10;
            bus.mem_en = 1'b1;
            bus.mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.wr_addr;
            q_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge sim_rst) begin
        if (sim_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVLW'(1);
                2'b01:   level <= level - LVLW'(1);
                default: ;
            endcase
        end
    end

    // RAM returns data one cycle after the read; register it once more for the display.
    always_ff @(posedge clk or posedge sim_rst) begin
        if (sim_rst) begin
            rd_pend        <= 1'b0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
        end else begin
            rd_pend        <= bus.disp_req;
            bus.disp_valid <= rd_pend;
            if (rd_pend) bus.disp_data <= bus.mem_rdata;
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge clk or posedge sim_rst) begin
        if (sim_rst) begin
            bus.stall_cnt <= '0;
            bus.max_level <= '0;
        end else begin
            if (bus.wr_valid && !bus.wr_ready && (bus.stall_cnt != 16'hFFFF))
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
            if (level > bus.max_level) bus.max_level <= level;
        end
    end
`endif
endmodule
